// File: rtl/mul_share_pkg.sv
// Shared types and default constants for the shared-multiplier controller.
// Holds the controller state encoding and the default operand width / watchdog limit.
package mul_share_pkg;

    localparam int W_DEF       = 8;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        SETTLE,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/mul_share_ctrl_if.sv
// Client-side and core-side signal bundle of the shared-multiplier controller.
// slave = controller view, master = environment (clients + multiplier core) view.
interface mul_share_ctrl_if #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic              resp_valid;
    logic [IDW-1:0]    resp_id;
    logic [2*W-1:0]    resp_product;
    logic              resp_err;
    logic              busy;
    logic              mul_start;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [2*W-1:0]    mul_product;
    logic              mul_ready;

    modport slave (
        input  req, a_in, b_in, mul_product, mul_ready,
        output gnt, resp_valid, resp_id, resp_product, resp_err, busy,
               mul_start, mul_a, mul_b
    );

    modport master (
        output req, a_in, b_in, mul_product, mul_ready,
        input  gnt, resp_valid, resp_id, resp_product, resp_err, busy,
               mul_start, mul_a, mul_b
    );
endinterface

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after ptr, wrapping.
// Zero latency; no state, the pointer is owned by the caller.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o
);

    always_comb begin
        logic found;
        int   c;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 1; k <= NREQ; k++) begin
            c = (int'(ptr_i) + k) % NREQ;
            if (!found && req_i[c]) begin
                found    = 1'b1;
                gnt_o[c] = 1'b1;
                idx_o    = IDW'(c);
            end
        end
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Round-robin front end sharing one sequential multiplier core; one operation in flight.
// req->gnt 1 cycle, result 11 cycles after win with a nominal core; requesters wait on req until gnt.
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int W       = W_DEF,
    parameter int IDW     = 2,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mul_share_ctrl_if.slave      bus
);

    localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   cur_id_q, cur_id_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [WDW-1:0]   wdog_q, wdog_d;
    logic [IDW-1:0]   rid_q, rid_d;
    logic [2*W-1:0]   rprod_q, rprod_d;
    logic             rerr_q, rerr_d;

    logic [NREQ-1:0]  win_oh;
    logic [IDW-1:0]   win_idx;

    rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .gnt_o (win_oh),
        .idx_o (win_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= IDW'(NREQ - 1);
            cur_id_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            wdog_q   <= '0;
            rid_q    <= '0;
            rprod_q  <= '0;
            rerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cur_id_q <= cur_id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            wdog_q   <= wdog_d;
            rid_q    <= rid_d;
            rprod_q  <= rprod_d;
            rerr_q   <= rerr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cur_id_d = cur_id_q;
        a_d      = a_q;
        b_d      = b_q;
        wdog_d   = wdog_q;
        rid_d    = rid_q;
        rprod_d  = rprod_q;
        rerr_d   = rerr_q;
        case (state_q)
            IDLE: begin
                if (|win_oh) begin
                    a_d      = bus.a_in[int'(win_idx) * W +: W];
                    b_d      = bus.b_in[int'(win_idx) * W +: W];
                    cur_id_d = win_idx;
                    ptr_d    = win_idx;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: state_d = SETTLE;
            // The core's ready may still show the previous result here; only RUN looks at it.
            SETTLE: begin
                wdog_d  = '0;
                state_d = RUN;
            end
            RUN: begin
                if (bus.mul_ready) begin
                    rprod_d = bus.mul_product;
                    rid_d   = cur_id_q;
                    rerr_d  = 1'b0;
                    state_d = DONE;
                end else if (wdog_q == WDW'(TIMEOUT - 1)) begin
                    rprod_d = '0;
                    rid_d   = cur_id_q;
                    rerr_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    wdog_d = wdog_q + WDW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.gnt        = '0;
        bus.mul_start  = 1'b0;
        bus.resp_valid = (state_q == DONE);
        bus.busy       = (state_q != IDLE);
        if (state_q == LAUNCH) begin
            bus.gnt[cur_id_q] = 1'b1;
            bus.mul_start     = 1'b1;
        end
    end

    assign bus.mul_a        = a_q;
    assign bus.mul_b        = b_q;
    assign bus.resp_id      = rid_q;
    assign bus.resp_product = rprod_q;
    assign bus.resp_err     = rerr_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Directed bench for mul_share_ctrl with a behavioural 8-cycle shift-add core model.
module tb_mul_share_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_err;
    logic stall;

    mul_share_ctrl_if #(.NREQ(4), .W(8), .IDW(2)) bus ();

    mul_share_ctrl #(.NREQ(4), .W(8), .IDW(2), .TIMEOUT(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core model: ready drops on the edge that samples start, rises 8 edges later.
    logic [7:0] pa, pb;
    int         cnt = 0;
    always @(posedge clk) begin
        if (bus.mul_start) begin
            pa            <= bus.mul_a;
            pb            <= bus.mul_b;
            cnt           <= 8;
            bus.mul_ready <= 1'b0;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1 && !stall) begin
                bus.mul_ready   <= 1'b1;
                bus.mul_product <= {8'h00, pa} * {8'h00, pb};
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_op(input string tag, input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] ep, input int elat, input logic eerr);
        int t0, gc, rc;
        logic [3:0]  gv;
        logic [7:0]  ma, mb;
        logic [1:0]  rid;
        logic [15:0] rp;
        logic        re;
        gc = -1; rc = -1; gv = '0; ma = '0; mb = '0; rid = '0; rp = '0; re = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.a_in[idx*8 +: 8] = a;
        bus.b_in[idx*8 +: 8] = b;
        bus.req = 4'(1 << idx);
        t0 = cyc;
        for (int k = 0; k < 40 && rc < 0; k++) begin
            tick();
            if (bus.gnt != '0 && gc < 0) begin
                gc = cyc - t0; gv = bus.gnt; ma = bus.mul_a; mb = bus.mul_b;
                check({tag, "_start"}, 32'(bus.mul_start), 32'd1);
            end else if (gc >= 0) begin
                bus.req = '0;
            end
            if (bus.resp_valid) begin
                rc = cyc - t0; rid = bus.resp_id; rp = bus.resp_product; re = bus.resp_err;
            end
        end
        bus.req = '0;
        check({tag, "_gnt"},      32'(gv),  32'(1 << idx));
        check({tag, "_gnt_cyc"},  32'(gc),  32'd1);
        check({tag, "_mul_ab"},   {16'h0, ma, mb}, {16'h0, a, b});
        check({tag, "_resp_cyc"}, 32'(rc),  32'(elat));
        check({tag, "_id"},       32'(rid), 32'(idx));
        check({tag, "_prod"},     32'(rp),  32'(ep));
        check({tag, "_err"},      32'(re),  32'(eerr));
        tick();
        check({tag, "_idle"},     32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0, bad, n_g1, g3_seen;
        logic [3:0]  gq[$];
        int          gcq[$];
        logic [1:0]  rq[$];
        logic [15:0] pq[$];
        n_chk = 0; n_err = 0; cyc = 0; stall = 1'b0;
        rst_n = 1'b0;
        bus.req = '0; bus.a_in = '0; bus.b_in = '0;
        #2;
        check("rst_gnt",   32'(bus.gnt), 32'd0);
        check("rst_flags", {28'h0, bus.resp_valid, bus.resp_err, bus.busy, bus.mul_start}, 32'd0);
        check("rst_resp",  {14'h0, bus.resp_id, bus.resp_product}, 32'd0);
        check("rst_mul",   {16'h0, bus.mul_a, bus.mul_b}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        run_op("single", 2, 8'd13, 8'd11, 16'd143, 11, 1'b0);
        run_op("zero_a", 0, 8'h00, 8'h5A, 16'h0000, 11, 1'b0);
        run_op("ff_ff",  1, 8'hFF, 8'hFF, 16'hFE01, 11, 1'b0);

        // Reset while in RUN; the core keeps counting and later shows a stale ready.
        bus.a_in = '0; bus.b_in = '0;
        bus.a_in[2*8 +: 8] = 8'd10; bus.b_in[2*8 +: 8] = 8'd10;
        bus.req = 4'b0100;
        t0 = cyc;
        while (cyc - t0 < 5) begin
            tick();
            if (cyc - t0 == 2) bus.req = '0;
        end
        check("midrst_busy_pre", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_flags", {28'h0, bus.resp_valid, bus.resp_err, bus.busy, bus.mul_start}, 32'd0);
        check("midrst_gnt",   32'(bus.gnt), 32'd0);
        check("midrst_resp",  {14'h0, bus.resp_id, bus.resp_product}, 32'd0);
        check("midrst_mul",   {16'h0, bus.mul_a, bus.mul_b}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.resp_valid || bus.busy) bad++;
        end
        check("stale_ready_ignored", 32'(bad), 32'd0);
        run_op("post_rst", 1, 8'd6, 8'd7, 16'd42, 11, 1'b0);

        stall = 1'b1;
        run_op("timeout", 0, 8'd9, 8'd9, 16'd0, 18, 1'b1);
        stall = 1'b0;
        run_op("after_to", 3, 8'd2, 8'd3, 16'd6, 11, 1'b0);

        // Requester 1 withdraws in the same cycle requester 3 arrives.
        bus.a_in = '0; bus.b_in = '0;
        bus.a_in[0 +: 8] = 8'd1;  bus.b_in[0 +: 8] = 8'd1;
        bus.a_in[8 +: 8] = 8'd9;  bus.b_in[8 +: 8] = 8'd9;
        bus.a_in[24 +: 8] = 8'd4; bus.b_in[24 +: 8] = 8'd5;
        bus.req = 4'b0001;
        t0 = cyc; n_g1 = 0; g3_seen = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (cyc - t0 == 2) bus.req = 4'b0010;
            if (cyc - t0 == 5) bus.req = 4'b1000;
            if (g3_seen != 0) bus.req = '0;
            if (bus.gnt[1]) n_g1++;
            if (bus.gnt[3]) g3_seen = 1;
            if (bus.gnt != '0) begin gq.push_back(bus.gnt); gcq.push_back(cyc - t0); end
            if (bus.resp_valid) begin rq.push_back(bus.resp_id); pq.push_back(bus.resp_product); end
        end
        bus.req = '0;
        check("wd_no_gnt1",   32'(n_g1), 32'd0);
        check("wd_n_gnt",     32'(gq.size()), 32'd2);
        check("wd_gnt3",      32'((gq.size() > 1) ? gq[1] : 4'h0), 32'h8);
        check("wd_gnt3_cyc",  32'((gcq.size() > 1) ? gcq[1] : -1), 32'd13);
        check("wd_n_resp",    32'(rq.size()), 32'd2);
        check("wd_resp_id",   32'((rq.size() > 1) ? rq[1] : 2'd0), 32'd3);
        check("wd_resp_prod", 32'((pq.size() > 1) ? pq[1] : 16'd0), 32'd20);

        // Fairness from a fresh reset (pointer at NREQ-1).
        do_reset();
        gq.delete(); gcq.delete(); rq.delete(); pq.delete();
        bus.a_in = {8'd7, 8'd5, 8'd3, 8'd1};
        bus.b_in = {8'd8, 8'd6, 8'd4, 8'd2};
        bus.req = 4'hF;
        t0 = cyc;
        for (int k = 0; k < 52; k++) begin
            tick();
            if (bus.gnt != '0) begin gq.push_back(bus.gnt); gcq.push_back(cyc - t0); end
            if (bus.resp_valid) begin rq.push_back(bus.resp_id); pq.push_back(bus.resp_product); end
        end
        bus.req = '0;
        check("fair_n_gnt", 32'(gq.size()), 32'd5);
        for (int g = 0; g < 5; g++) begin
            check($sformatf("fair_gnt%0d", g),     32'((gq.size() > g) ? gq[g] : 4'h0), 32'(1 << (g % 4)));
            check($sformatf("fair_gnt%0d_cyc", g), 32'((gcq.size() > g) ? gcq[g] : -1), 32'(1 + 12 * g));
        end
        check("fair_n_resp", 32'(rq.size()), 32'd4);
        for (int r = 0; r < 4; r++) begin
            check($sformatf("fair_id%0d", r), 32'((rq.size() > r) ? rq[r] : 2'd0), 32'(r));
        end
        check("fair_p0", 32'((pq.size() > 0) ? pq[0] : 16'hFFFF), 32'd2);
        check("fair_p1", 32'((pq.size() > 1) ? pq[1] : 16'hFFFF), 32'd12);
        check("fair_p2", 32'((pq.size() > 2) ? pq[2] : 16'hFFFF), 32'd30);
        check("fair_p3", 32'((pq.size() > 3) ? pq[3] : 16'hFFFF), 32'd56);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
